// File: rtl/traffic_light_controller_2way.sv
// traffic_light_controller_2way: main/side crossing sequencer with all-red clearance, pedestrian walk and night flash
module traffic_light_controller_2way #(
  parameter int CNT_W       = 8,
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int PED_TIME    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic             main_R,
  output logic             main_G,
  output logic             side_R,
  output logic             side_G,
  output logic             ped_walk,
  output logic             ped_pending,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remain
);
  typedef enum logic [2:0] {
    MAIN_GREEN, MAIN_YELLOW, ALLRED_A, SIDE_GREEN, SIDE_YELLOW, ALLRED_B, PED_WALK, FLASH
  } state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0] lamp_nxt;
  logic flash_on, flash_nxt, pend_nxt, go;
  function automatic logic [CNT_W-1:0] load(state_t s);
    case (s)
      MAIN_GREEN, SIDE_GREEN:   load = CNT_W'(GREEN_TIME - 1);
      MAIN_YELLOW, SIDE_YELLOW: load = CNT_W'(YELLOW_TIME - 1);
      ALLRED_A, ALLRED_B:       load = CNT_W'(ALLRED_TIME - 1);
      PED_WALK:                 load = CNT_W'(PED_TIME - 1);
      default:                  load = '0;
    endcase
  endfunction
  always_comb begin
    nxt = state;
    go = tick_en && (state == FLASH ? !night_mode : remain == '0);
    if (go)
      case (state)
        MAIN_GREEN:  nxt = MAIN_YELLOW;
        MAIN_YELLOW: nxt = ALLRED_A;
        ALLRED_A:    nxt = night_mode ? FLASH : SIDE_GREEN;
        SIDE_GREEN:  nxt = SIDE_YELLOW;
        SIDE_YELLOW: nxt = ALLRED_B;
        ALLRED_B:    nxt = night_mode ? FLASH : ped_pending ? PED_WALK : MAIN_GREEN;
        PED_WALK:    nxt = MAIN_GREEN;
        FLASH:       nxt = ALLRED_B;
      endcase
    cnt_nxt = nxt != state ? load(nxt) : (tick_en && remain != '0) ? remain - 1'b1 : remain;
    // flash starts on yellow and flips on every tick while night mode holds
    flash_nxt = nxt == FLASH && (state != FLASH || (flash_on ^ tick_en));
    pend_nxt = (nxt == PED_WALK && state != PED_WALK) ? 1'b0 : ped_pending || (ped_req && state != PED_WALK);
    lamp_nxt = nxt == FLASH ? {4{flash_nxt}} :
               {nxt != MAIN_GREEN, nxt inside {MAIN_GREEN, MAIN_YELLOW},
                nxt != SIDE_GREEN, nxt inside {SIDE_GREEN, SIDE_YELLOW}};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ALLRED_B;
      remain <= CNT_W'(ALLRED_TIME - 1);
      flash_on <= 1'b0;
      ped_pending <= 1'b0;
      {main_R, main_G, side_R, side_G} <= 4'b1010;
      ped_walk <= 1'b0;
    end else begin
      state <= nxt;
      remain <= cnt_nxt;
      flash_on <= flash_nxt;
      ped_pending <= pend_nxt;
      {main_R, main_G, side_R, side_G} <= lamp_nxt;
      ped_walk <= nxt == PED_WALK;
    end
  assign phase = state;
endmodule

// File: tb/tb_traffic_light_controller_2way.sv
// tb_traffic_light_controller_2way: scoreboard of expected phase entries checked by negedge monitors
module tb_traffic_light_controller_2way;
  logic clk = 0, reset = 1, tick_en = 0, ped_req = 0, night_mode = 0, tick_on = 0;
  logic main_R, main_G, side_R, side_G, ped_walk, ped_pending;
  logic m6_r, m6_g, s6_r, s6_g, walk6, pend6;
  logic [2:0] phase, phase6;
  logic [7:0] remain;
  logic [3:0] remain6;
  int total = 0, passed = 0, ticks = 0, ticks6 = 0, div = 0;
  bit done6 = 0;
  typedef struct {int p; int d; int pe;} rec_t;
  rec_t q[$], q6[$], cur, cur6;

  traffic_light_controller_2way dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .ped_req(ped_req), .night_mode(night_mode),
    .main_R(main_R), .main_G(main_G), .side_R(side_R), .side_G(side_G),
    .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase), .remain(remain)
  );
  traffic_light_controller_2way #(.CNT_W(4), .GREEN_TIME(16), .YELLOW_TIME(1), .ALLRED_TIME(1), .PED_TIME(1)) dut6 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .ped_req(1'b0), .night_mode(1'b0),
    .main_R(m6_r), .main_G(m6_g), .side_R(s6_r), .side_G(s6_g),
    .ped_walk(walk6), .ped_pending(pend6), .phase(phase6), .remain(remain6)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  // lamp nibble {main_R, main_G, side_R, side_G}
  function automatic int lamps_of(int p);
    case (p)
      0: return 4'b0110;
      1: return 4'b1110;
      3: return 4'b1001;
      4: return 4'b1011;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic int rem_of(int p);
    case (p)
      0, 3: return 9;
      1, 4: return 2;
      2, 5: return 1;
      6: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic push(int p, int d, int pe);
    q.push_back('{p, d, pe});
  endtask

  task automatic cyc(int pe);
    push(1, 3, pe); push(2, 2, pe); push(3, 10, pe); push(4, 3, pe); push(5, 2, pe);
  endtask

  task automatic wait_phase(int p);
    int n = 0;
    while (int'(phase) != p && n < 500) begin @(negedge clk); n++; end
    chk("reach_phase", int'(phase), p);
  endtask

  initial forever begin
    @(posedge clk); #1;
    tick_en = tick_on && div == 3;
    div = (div + 1) % 4;
  end

  always @(negedge clk) begin
    if (int'(phase) != cur.p) begin
      if (cur.d != 0) chk("duration", ticks, cur.d);
      chk("phase_seq", int'(phase), q.size() > 0 ? q[0].p : -1);
      cur = q.size() > 0 ? q.pop_front() : '{int'(phase), 0, 0};
      chk("entry_pending", int'(ped_pending), cur.pe);
      ticks = 0;
    end
    chk("lamps", int'({main_R, main_G, side_R, side_G}), cur.p == 7 ? (ticks % 2 == 1 ? 0 : 15) : lamps_of(cur.p));
    chk("ped_walk", int'(ped_walk), int'(cur.p == 6));
    chk("remain", int'(remain), cur.p == 7 ? 0 : rem_of(cur.p) - ticks);
    if (tick_en) ticks++;
  end

  always @(negedge clk) if (!done6) begin
    if (int'(phase6) != cur6.p) begin
      chk("duration6", ticks6, cur6.d);
      chk("phase_seq6", int'(phase6), q6.size() > 0 ? q6[0].p : -1);
      cur6 = q6.size() > 0 ? q6.pop_front() : '{int'(phase6), 0, 0};
      ticks6 = 0;
      done6 = q6.size() == 0;
    end
    chk("remain6", int'(remain6), (cur6.p == 0 || cur6.p == 3 ? 15 : 0) - ticks6);
    if (tick_en) ticks6++;
  end

  initial begin
    cur = '{5, 2, 0};
    cur6 = '{5, 1, 0};
    q6.push_back('{0, 16, 0}); q6.push_back('{1, 1, 0}); q6.push_back('{2, 1, 0});
    q6.push_back('{3, 16, 0}); q6.push_back('{4, 1, 0}); q6.push_back('{5, 1, 0});
    q6.push_back('{0, 0, 0});
    push(0, 10, 0); cyc(0);
    push(0, 10, 0); cyc(1); push(6, 6, 0);
    push(0, 10, 0); cyc(1); push(6, 6, 0);
    push(0, 10, 0); cyc(1); push(6, 6, 0);
    push(0, 10, 0); push(1, 3, 0); push(2, 2, 0); push(7, 0, 0); push(5, 2, 0);
    push(0, 10, 0); push(1, 3, 0); push(2, 2, 0); push(3, 0, 0); push(5, 2, 0); push(0, 0, 0);
    #1 reset = 0;
    #1;
    chk("rst_phase", int'(phase), 5);
    chk("rst_remain", int'(remain), 1);
    chk("rst_lamps", int'({main_R, main_G, side_R, side_G}), 4'b1010);
    chk("rst_walk", int'(ped_walk), 0);
    chk("rst_pending", int'(ped_pending), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1; tick_on = 1;
    wait_phase(0); wait_phase(5); wait_phase(0);
    repeat (3) @(negedge clk);
    #2 ped_req = 1;
    @(negedge clk);
    #2 ped_req = 0;
    chk("pend_set", int'(ped_pending), 1);
    wait_phase(6); wait_phase(0);
    chk("pend_served", int'(ped_pending), 0);
    #2 ped_req = 1;
    wait_phase(6);
    repeat (3) @(negedge clk);
    chk("pend_in_walk", int'(ped_pending), 0);
    wait_phase(0);
    @(negedge clk);
    chk("pend_reset_mg", int'(ped_pending), 1);
    #2 ped_req = 0;
    wait_phase(6); wait_phase(0);
    repeat (8) @(negedge clk);
    #2 night_mode = 1;
    wait_phase(7);
    repeat (20) @(negedge clk);
    #2 night_mode = 0;
    wait_phase(5); wait_phase(0);
    wait_phase(3);
    for (int n = 0; n < 100 && remain != 8'd5; n++) @(negedge clk);
    chk("sg_remain5", int'(remain), 5);
    #2 reset = 0; tick_on = 0; tick_en = 0;
    #1;
    chk("abort_phase", int'(phase), 5);
    chk("abort_remain", int'(remain), 1);
    chk("abort_lamps", int'({main_R, main_G, side_R, side_G}), 4'b1010);
    repeat (2) @(negedge clk);
    #2 reset = 1; tick_on = 1;
    wait_phase(0);
    repeat (4) @(negedge clk);
    chk("queue_left", q.size(), 0);
    chk("dut6_done", int'(done6), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
